board_cursor_ctrl: RTL

Parametrised board-cursor and move-selection controller for the checkers front end. It sits between the raw active-low push-buttons and the game/rules logic. It debounces five buttons (four directions and select) and moves a cursor over a COLS×ROWS board with either wrap or clamp at the edges. A two-press select sequence (source square, then destination square) produces a move request, held under a valid/ready handshake until the rules logic accepts it.

---
 rtl/board_cursor_pkg.sv | 36 +++
 rtl/btn_debounce.sv | 56 +++++
 rtl/board_cursor_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/board_cursor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : board_cursor_pkg                                              |
// | Desc     : Shared types, direction indices and wrap/clamp step helper.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package board_cursor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SRC  = 2'd1,
        PEND = 2'd2
    } sel_state_e;

    localparam int UP    = 0;
    localparam int DOWN  = 1;
    localparam int LEFT  = 2;
    localparam int RIGHT = 3;

    // Opposing requests on the same edge cancel; otherwise one step with wrap or clamp.
    function automatic int coord_step(input int pos, input logic inc, input logic dec,
                                      input int max_pos, input logic wrap);
        int nxt;
        nxt = pos;
        if (inc && !dec) begin
            if (pos >= max_pos) nxt = wrap ? 0 : max_pos;
            else                nxt = pos + 1;
        end else if (dec && !inc) begin
            if (pos <= 0) nxt = wrap ? max_pos : 0;
            else          nxt = pos - 1;
        end
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : btn_debounce                                                  |
// | Desc     : 2-flop synchroniser, stability counter and press-edge pulse.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic pressed,
    output logic press
);
    localparam int c_CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_clean_n;
    logic               r_press;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_diff;
    logic               w_done;

    assign w_diff = (r_sync2 != r_clean_n);
    assign w_done = w_diff && (r_cnt == c_CNT_W'(DEB_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_clean_n <= 1'b1;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= raw_n;
            r_sync2 <= r_sync1;
            // Pulse only on the released-to-pressed transition of the clean level.
            r_press <= w_done && r_clean_n;
            if (w_done) begin
                r_clean_n <= r_sync2;
                r_cnt     <= '0;
            end else if (w_diff) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign pressed = ~r_clean_n;
    assign press   = r_press;

endmodule
`default_nettype wire

// File: rtl/board_cursor_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : board_cursor_ctrl                                             |
// | Desc     : Debounced cursor over a COLS x ROWS board plus two-press move |
// |            selection with valid/ready hand-off. CURSOR_AUTOREPEAT_EN     |
// |            enables held-button auto-repeat.                              |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module board_cursor_ctrl
    import board_cursor_pkg::*;
#(
    parameter int COLS       = 8,
    parameter int ROWS       = 8,
    parameter int DEB_CYCLES = 4,
    parameter int WRAP       = 1,
    parameter int REP_DELAY  = 16,
    parameter int REP_PERIOD = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              btn_n,
    input  logic                    sel_n,
    output logic [$clog2(COLS)-1:0] cur_x,
    output logic [$clog2(ROWS)-1:0] cur_y,
    output logic [$clog2(COLS)-1:0] src_x,
    output logic [$clog2(ROWS)-1:0] src_y,
    output logic [$clog2(COLS)-1:0] dst_x,
    output logic [$clog2(ROWS)-1:0] dst_y,
    output logic                    src_held,
    output logic                    move_valid,
    input  logic                    move_ready
);
    localparam int c_XW = $clog2(COLS);
    localparam int c_YW = $clog2(ROWS);

    logic [4:0] w_raw_n;
    logic [4:0] w_held;
    logic [4:0] w_press;
    logic [3:0] w_step;

    assign w_raw_n = {sel_n, btn_n};

    generate
        for (genvar i = 0; i < 5; i++) begin : g_deb
            btn_debounce #(
                .DEB_CYCLES (DEB_CYCLES)
            ) u_deb (
                .clk     (clk),
                .rst     (rst),
                .raw_n   (w_raw_n[i]),
                .pressed (w_held[i]),
                .press   (w_press[i])
            );
        end
    endgenerate

`ifdef CURSOR_AUTOREPEAT_EN
    localparam int c_REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int c_REP_W   = $clog2(c_REP_MAX + 1);

    logic w_unused_sel_held;
    assign w_unused_sel_held = w_held[4];

    generate
        for (genvar i = 0; i < 4; i++) begin : g_rep
            logic [c_REP_W-1:0] r_cnt;
            logic               r_first;
            logic               w_rep;

            // First repeat after REP_DELAY, then every REP_PERIOD while held.
            assign w_rep = w_held[i] &&
                           ((r_first  && (r_cnt == c_REP_W'(REP_DELAY))) ||
                            (!r_first && (r_cnt == c_REP_W'(REP_PERIOD))));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt   <= '0;
                    r_first <= 1'b0;
                end else if (!w_held[i]) begin
                    r_cnt   <= '0;
                    r_first <= 1'b0;
                end else if (w_press[i]) begin
                    r_cnt   <= c_REP_W'(1);
                    r_first <= 1'b1;
                end else if (w_rep) begin
                    r_cnt   <= c_REP_W'(1);
                    r_first <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + c_REP_W'(1);
                end
            end

            assign w_step[i] = w_press[i] | w_rep;
        end
    endgenerate
`else
    localparam int c_unused_rep = REP_DELAY + REP_PERIOD;
    logic w_unused_held;
    assign w_unused_held = ^w_held;
    assign w_step        = w_press[3:0];
`endif

    sel_state_e       r_state, w_state_nxt;
    logic [c_XW-1:0]  r_cur_x, w_cur_x_nxt, r_src_x, w_src_x_nxt, r_dst_x, w_dst_x_nxt;
    logic [c_YW-1:0]  r_cur_y, w_cur_y_nxt, r_src_y, w_src_y_nxt, r_dst_y, w_dst_y_nxt;
    logic             r_src_held, w_src_held_nxt;
    logic             r_move_valid, w_move_valid_nxt;
    logic             w_sel;

    assign w_sel = w_press[4];

    always_comb begin
        w_state_nxt      = r_state;
        w_cur_x_nxt      = r_cur_x;
        w_cur_y_nxt      = r_cur_y;
        w_src_x_nxt      = r_src_x;
        w_src_y_nxt      = r_src_y;
        w_dst_x_nxt      = r_dst_x;
        w_dst_y_nxt      = r_dst_y;
        w_src_held_nxt   = r_src_held;
        w_move_valid_nxt = r_move_valid;

        if (r_state != PEND) begin
            w_cur_x_nxt = c_XW'(coord_step(int'(r_cur_x), w_step[RIGHT], w_step[LEFT],
                                           COLS - 1, WRAP != 0));
            w_cur_y_nxt = c_YW'(coord_step(int'(r_cur_y), w_step[UP], w_step[DOWN],
                                           ROWS - 1, WRAP != 0));
        end

        // Selection compares against the pre-move cursor held in r_cur_*.
        unique case (r_state)
            IDLE: begin
                if (w_sel) begin
                    w_src_x_nxt    = r_cur_x;
                    w_src_y_nxt    = r_cur_y;
                    w_src_held_nxt = 1'b1;
                    w_state_nxt    = SRC;
                end
            end
            SRC: begin
                if (w_sel) begin
                    if ((r_cur_x == r_src_x) && (r_cur_y == r_src_y)) begin
                        w_src_held_nxt = 1'b0;
                        w_state_nxt    = IDLE;
                    end else begin
                        w_dst_x_nxt      = r_cur_x;
                        w_dst_y_nxt      = r_cur_y;
                        w_move_valid_nxt = 1'b1;
                        w_state_nxt      = PEND;
                    end
                end
            end
            PEND: begin
                if (r_move_valid && move_ready) begin
                    w_move_valid_nxt = 1'b0;
                    w_src_held_nxt   = 1'b0;
                    w_state_nxt      = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cur_x      <= '0;
            r_cur_y      <= '0;
            r_src_x      <= '0;
            r_src_y      <= '0;
            r_dst_x      <= '0;
            r_dst_y      <= '0;
            r_src_held   <= 1'b0;
            r_move_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cur_x      <= w_cur_x_nxt;
            r_cur_y      <= w_cur_y_nxt;
            r_src_x      <= w_src_x_nxt;
            r_src_y      <= w_src_y_nxt;
            r_dst_x      <= w_dst_x_nxt;
            r_dst_y      <= w_dst_y_nxt;
            r_src_held   <= w_src_held_nxt;
            r_move_valid <= w_move_valid_nxt;
        end
    end

    assign cur_x      = r_cur_x;
    assign cur_y      = r_cur_y;
    assign src_x      = r_src_x;
    assign src_y      = r_src_y;
    assign dst_x      = r_dst_x;
    assign dst_y      = r_dst_y;
    assign src_held   = r_src_held;
    assign move_valid = r_move_valid;

endmodule
`default_nettype wire
